// File: rtl/ic_diag_pkg.sv
// Shared types for the I-cache diagnostic fanout buffer: packet layout, default
// sizing and the even-parity helper used when IC_DIAG_PARITY_EN is defined.
package ic_diag_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DEPTH  = 2;
    localparam int PTR_W      = $clog2(DEF_DEPTH);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ic_diag_pkt_t;

    // Even parity: stored bit makes the XOR over {bit, packet} zero.
    function automatic logic ic_diag_par(input ic_diag_pkt_t pkt);
        return ^pkt;
    endfunction

endpackage

// File: rtl/ic_diag_fanout_buf_if.sv
// Producer/consumer bundle for the diagnostic fanout buffer; master drives
// packets and per-channel ready, slave is the buffer itself.
interface ic_diag_fanout_buf_if
    import ic_diag_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
);
    logic                       in_valid;
    logic                       in_ready;
    logic [ADDR_W-1:0]          in_addr;
    logic [DATA_W-1:0]          in_data;
    logic                       in_wr;
    logic [NUM_CH-1:0]          out_valid;
    logic [NUM_CH-1:0]          out_ready;
    logic [NUM_CH*ADDR_W-1:0]   out_addr;
    logic [NUM_CH*DATA_W-1:0]   out_data;
    logic [NUM_CH-1:0]          out_wr;

    modport master (
        output in_valid, in_addr, in_data, in_wr, out_ready,
        input  in_ready, out_valid, out_addr, out_data, out_wr
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_wr, out_ready,
        output in_ready, out_valid, out_addr, out_data, out_wr
    );
endinterface

// File: rtl/ic_diag_fifo.sv
// One consumer channel: small register FIFO whose head output keeps showing the
// last popped packet while empty. Parity storage/check under IC_DIAG_PARITY_EN.
module ic_diag_fifo
    import ic_diag_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         push,
    input  ic_diag_pkt_t push_pkt,
    input  logic         pop_ready,
    output logic         full,
    output logic         valid,
    output ic_diag_pkt_t head,
    output logic         par_err
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int PKT_W = $bits(ic_diag_pkt_t);
`ifdef IC_DIAG_PARITY_EN
    localparam int EW = PKT_W + 1;
`else
    localparam int EW = PKT_W;
`endif

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [EW-1:0] ent_arr [DEPTH];
    logic [EW-1:0] wr_ent;
    logic [EW-1:0] rd_ent;
    logic [PW-1:0] head_idx;
    logic          pop;

`ifdef IC_DIAG_PARITY_EN
    assign wr_ent = {ic_diag_par(push_pkt), push_pkt};
`else
    assign wr_ent = push_pkt;
`endif

    assign full  = (count_reg == CW'(DEPTH));
    assign valid = (count_reg != '0);
    assign pop   = valid & pop_ready;

    // While empty, present the slot just behind the read pointer (last popped).
    assign head_idx = valid ? rd_ptr_reg : rd_ptr_reg - 1'b1;
    assign rd_ent   = ent_arr[head_idx];
    assign head     = ic_diag_pkt_t'(rd_ent[PKT_W-1:0]);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [EW-1:0] ent_reg;

            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    ent_reg <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    ent_reg <= wr_ent;
                end
            end

            assign ent_arr[gi] = ent_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

`ifdef IC_DIAG_PARITY_EN
    logic par_err_reg;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            par_err_reg <= 1'b0;
        end else if (pop && (rd_ent[PKT_W] != ic_diag_par(head))) begin
            par_err_reg <= 1'b1;
        end
    end

    assign par_err = par_err_reg;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/ic_diag_fanout_buf.sv
// Broadcasts each accepted I-cache diag packet into NUM_CH independent FIFOs.
// Optional per-entry parity is enabled by defining IC_DIAG_PARITY_EN.
module ic_diag_fanout_buf
    import ic_diag_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_l,
    ic_diag_fanout_buf_if.slave  bus,
    output logic                 busy,
    output logic [NUM_CH-1:0]    par_err
);
    logic [NUM_CH-1:0] full_v;
    logic [NUM_CH-1:0] valid_v;
    logic [NUM_CH-1:0] par_err_v;
    ic_diag_pkt_t      head_pkt [NUM_CH];
    ic_diag_pkt_t      in_pkt;
    logic              accept;

    // Conservative: a full channel blocks the producer even if it pops this cycle.
    assign bus.in_ready = rst_l & ~(|full_v);
    assign accept       = bus.in_valid & bus.in_ready;
    assign in_pkt       = '{wr: bus.in_wr, addr: bus.in_addr, data: bus.in_data};

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ic_diag_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_l     (rst_l),
                .push      (accept),
                .push_pkt  (in_pkt),
                .pop_ready (bus.out_ready[gi]),
                .full      (full_v[gi]),
                .valid     (valid_v[gi]),
                .head      (head_pkt[gi]),
                .par_err   (par_err_v[gi])
            );

            assign bus.out_addr[gi*ADDR_W +: ADDR_W] = head_pkt[gi].addr;
            assign bus.out_data[gi*DATA_W +: DATA_W] = head_pkt[gi].data;
            assign bus.out_wr[gi]                    = head_pkt[gi].wr;
        end
    endgenerate

    assign bus.out_valid = valid_v;
    assign busy          = |valid_v;
    assign par_err       = par_err_v;

endmodule

// File: tb/tb_ic_diag_fanout_buf.sv
// Bench for ic_diag_fanout_buf: scoreboard of per-channel queues plus a vector
// table and hand sequences; parity fault injection runs when IC_DIAG_PARITY_EN is set.
module tb_ic_diag_fanout_buf;
    import ic_diag_pkg::*;

    localparam int NCH = 4;

    typedef struct {
        logic        iv;
        logic [15:0] a;
        logic [31:0] d;
        logic        w;
        logic [3:0]  ordy;
        logic        e_ir;
        logic [3:0]  e_ov;
        logic        e_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic busy, busy4;
    logic [NCH-1:0] par_err, par_err4;

    int n_vec = 0;
    int n_err = 0;

    ic_diag_pkt_t sb_q [NCH][$];
    vec_t         tbl[$];

    ic_diag_fanout_buf_if #(.NUM_CH(NCH)) bus ();
    ic_diag_fanout_buf_if #(.NUM_CH(NCH)) bus4 ();

    ic_diag_fanout_buf #(.NUM_CH(NCH), .DEPTH(2)) dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .bus     (bus),
        .busy    (busy),
        .par_err (par_err)
    );

    ic_diag_fanout_buf #(.NUM_CH(NCH), .DEPTH(4)) dut4 (
        .clk     (clk),
        .rst_l   (rst_l),
        .bus     (bus4),
        .busy    (busy4),
        .par_err (par_err4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        cyc();
        bus.in_valid  = v.iv;
        bus.in_addr   = v.a;
        bus.in_data   = v.d;
        bus.in_wr     = v.w;
        bus.out_ready = v.ordy;
        chk($sformatf("vec%0d.in_ready", idx), 64'(bus.in_ready), 64'(v.e_ir));
        chk($sformatf("vec%0d.out_valid", idx), 64'(bus.out_valid), 64'(v.e_ov));
        chk($sformatf("vec%0d.busy", idx), 64'(busy), 64'(v.e_busy));
        chk($sformatf("vec%0d.par_err", idx), 64'(par_err), 64'd0);
    endtask

    // Scoreboard: compare pops against the queue, then record newly accepted packets.
    always @(negedge clk) begin
        ic_diag_pkt_t got, exp_pkt;
        if (!rst_l) begin
            for (int k = 0; k < NCH; k++) sb_q[k].delete();
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    got.wr   = bus.out_wr[k];
                    got.addr = bus.out_addr[k*ADDR_W +: ADDR_W];
                    got.data = bus.out_data[k*DATA_W +: DATA_W];
                    if (sb_q[k].size() == 0) begin
                        chk($sformatf("ch%0d.unexpected_pop", k), 64'(got), 64'd0 - 64'd1);
                    end else begin
                        exp_pkt = sb_q[k].pop_front();
                        $display("ch%0d pop addr=%h data=%h wr=%0d", k, got.addr, got.data, got.wr);
                        chk($sformatf("ch%0d.pop_pkt", k), 64'(got), 64'(exp_pkt));
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int k = 0; k < NCH; k++)
                    sb_q[k].push_back('{wr: bus.in_wr, addr: bus.in_addr, data: bus.in_data});
            end
        end
    end

    initial begin
        bus.in_valid = 0; bus.in_addr = '0; bus.in_data = '0; bus.in_wr = 0; bus.out_ready = '0;
        bus4.in_valid = 0; bus4.in_addr = '0; bus4.in_data = '0; bus4.in_wr = 0; bus4.out_ready = '0;

        // Stall on ch2: fill it, see in_ready drop while others are empty, then release.
        tbl.push_back('{1'b1, 16'h1111, 32'hA0A0A0A0, 1'b0, 4'b1011, 1'b1, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 16'h2222, 32'hB1B1B1B1, 1'b1, 4'b1011, 1'b1, 4'b1111, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 32'h00000000, 1'b0, 4'b1011, 1'b0, 4'b1111, 1'b1});
        tbl.push_back('{1'b1, 16'h3333, 32'hC2C2C2C2, 1'b0, 4'b1011, 1'b0, 4'b0100, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 32'h00000000, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 32'h00000000, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0});

        // Reset state
        repeat (2) cyc();
        chk("rst.in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.par_err", 64'(par_err), 64'd0);
        chk("rst.out_addr", 64'(bus.out_addr), 64'd0);
        chk("rst.out_data0", 64'(bus.out_data[31:0]), 64'd0);
        rst_l = 1'b1;
        cyc();

        // Single broadcast push
        bus.in_valid = 1; bus.in_addr = 16'h0040; bus.in_data = 32'hDEADBEEF; bus.in_wr = 1;
        chk("t1.in_ready", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_valid = 0;
        chk("t1.out_valid", 64'(bus.out_valid), 64'hF);
        chk("t1.busy", 64'(busy), 64'd1);
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("t1.head_addr%0d", k), 64'(bus.out_addr[k*16 +: 16]), 64'h0040);
            chk($sformatf("t1.head_data%0d", k), 64'(bus.out_data[k*32 +: 32]), 64'hDEADBEEF);
            chk($sformatf("t1.head_wr%0d", k), 64'(bus.out_wr[k]), 64'd1);
        end
        bus.out_ready = 4'hF;
        cyc();
        bus.out_ready = 4'h0;
        chk("t1.drained_valid", 64'(bus.out_valid), 64'd0);
        chk("t1.drained_busy", 64'(busy), 64'd0);
        chk("t1.hold_data3", 64'(bus.out_data[3*32 +: 32]), 64'hDEADBEEF);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Sustained 1 packet/cycle with all consumers ready
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1; bus.in_addr = 16'(16'h0100 + i); bus.in_data = 32'h5000_0000 + i;
            bus.in_wr = i[0]; bus.out_ready = 4'hF;
            chk($sformatf("t3.in_ready%0d", i), 64'(bus.in_ready), 64'd1);
            if (i > 0) chk($sformatf("t3.out_valid%0d", i), 64'(bus.out_valid), 64'hF);
            cyc();
        end
        bus.in_valid = 0;
        chk("t3.tail_valid", 64'(bus.out_valid), 64'hF);
        cyc();
        bus.out_ready = 0;
        chk("t3.end_busy", 64'(busy), 64'd0);

        // Mid-stream reset discards queued packets
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_addr = 16'(16'h0A00 + i); bus.in_data = 32'h7700_0000 + i; bus.in_wr = 0;
            chk($sformatf("t4.in_ready%0d", i), 64'(bus.in_ready), (i == 2) ? 64'd0 : 64'd1);
            cyc();
        end
        bus.in_valid = 0;
        rst_l = 1'b0;
        #1;
        chk("t4.rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t4.rst_busy", 64'(busy), 64'd0);
        chk("t4.rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t4.rst_data", 64'(bus.out_data[31:0]), 64'd0);
        repeat (2) cyc();
        rst_l = 1'b1;
        cyc();
        chk("t4.post_valid", 64'(bus.out_valid), 64'd0);
        chk("t4.post_busy", 64'(busy), 64'd0);
        cyc();
        chk("t4.post_valid2", 64'(bus.out_valid), 64'd0);

`ifdef IC_DIAG_PARITY_EN
        begin
            logic [$bits(ic_diag_pkt_t):0] fv;
            ic_diag_pkt_t tmp;
            bus.in_valid = 1; bus.in_addr = 16'h0C0C; bus.in_data = 32'h12345678; bus.in_wr = 1;
            cyc();
            bus.in_valid = 0;
            fv = dut.g_ch[1].u_fifo.g_ent[0].ent_reg;
            fv[0] = ~fv[0];
            force dut.g_ch[1].u_fifo.g_ent[0].ent_reg = fv;
            tmp = sb_q[1][0];
            tmp.data[0] = ~tmp.data[0];
            sb_q[1][0] = tmp;
            bus.out_ready = 4'hF;
            cyc();
            bus.out_ready = 0;
            release dut.g_ch[1].u_fifo.g_ent[0].ent_reg;
            chk("t5.par_err", 64'(par_err), 64'b0010);
            repeat (2) cyc();
            chk("t5.par_sticky", 64'(par_err), 64'b0010);
            rst_l = 1'b0;
            #1;
            chk("t5.par_rst", 64'(par_err), 64'd0);
            cyc();
            rst_l = 1'b1;
            cyc();
        end
`endif

        // Fresh packet after reset flows normally
        bus.in_valid = 1; bus.in_addr = 16'h0BEE; bus.in_data = 32'hCAFEF00D; bus.in_wr = 1; bus.out_ready = 4'hF;
        cyc();
        bus.in_valid = 0;
        chk("t4.fresh_valid", 64'(bus.out_valid), 64'hF);
        cyc();
        bus.out_ready = 0;
        chk("t4.fresh_busy", 64'(busy), 64'd0);

        // Pointer wrap on the DEPTH=4 instance
        for (int i = 0; i < 5; i++) begin
            bus4.in_valid = 1; bus4.in_addr = 16'(16'h0D00 + i); bus4.in_data = 32'h9000_0000 + i; bus4.in_wr = i[0];
            cyc();
            bus4.in_valid = 0;
            chk($sformatf("t6.valid%0d", i), 64'(bus4.out_valid), 64'hF);
            chk($sformatf("t6.data0_%0d", i), 64'(bus4.out_data[31:0]), 64'h9000_0000 + i);
            chk($sformatf("t6.addr3_%0d", i), 64'(bus4.out_addr[3*16 +: 16]), 64'(16'h0D00 + i));
            bus4.out_ready = 4'hF;
            cyc();
            bus4.out_ready = 0;
            $display("dut4 pair %0d popped data=%h", i, bus4.out_data[31:0]);
        end
        chk("t6.end_valid", 64'(bus4.out_valid), 64'd0);
        chk("t6.end_busy", 64'(busy4), 64'd0);
        chk("t6.par_err", 64'(par_err4), 64'd0);

        cyc();
        for (int k = 0; k < NCH; k++) chk($sformatf("sb.leftover%0d", k), 64'(sb_q[k].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
